quant_act_pack: RTL and testbench
=================================

# quant_act_pack

Post-accumulation stage of the convolution datapath, directly downstream of the 4-output adder tree. It takes four 22-bit signed partial-sum outputs plus the adder-tree valid, then applies a per-layer rounding right-shift and optional leaky ReLU. It saturates each result to int8 and packs the four bytes into one 32-bit word. Words are buffered in a small FIFO and drained to the output-buffer writer over a valid/ready handshake; a layer-done pulse fires after the programmed word count.

## Interface
- DEPTH, 8: FIFO entries; power of two, at least 4.
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- vld_i  in  1  input word valid; driven by the adder tree's add_vld; no backpressure.
- iSum0..iSum3  in  22 each  signed channel sums, ch0..ch3.
- iShift  in  5  right-shift amount, 0..21; quasi-static per layer.
- iActEn  in  1  1 = leaky ReLU, 0 = identity; quasi-static.
- iFrameLen  in  16  output words per layer; 0 disables done.
- iClr  in  1  synchronous clear of pipeline, FIFO, counter, ovf.
- o_data  out  32  packed word: [7:0]=ch0, [15:8]=ch1, [23:16]=ch2, [31:24]=ch3.
- o_vld  out  1  FIFO non-empty.
- i_rdy  in  1  consumer ready; pop on o_vld & i_rdy.
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy.
- o_ovf  out  1  sticky: a word was dropped on a full FIFO.
- o_done  out  1  one-cycle pulse when the layer's last word is popped.

## Operation
- The same math is applied per channel, across 3 register stages plus a FIFO write.
- S1, round-shift:
  - Sign-extend to 23 bits.
  - If iShift is non-zero, add 1<<(iShift-1).
  - Arithmetic right shift by iShift (round half up toward +inf).
- S2, activation: if iActEn and the value is negative, the value becomes value>>>3 (floor). Otherwise it passes through.
- S3, saturate and pack: clamp to [-128,127], take the two's-complement byte, pack the four bytes.
- FIFO write (push) occurs when the S3 valid is set:
  - Not full: push.
  - Full and pop in the same cycle: push accepted, occupancy unchanged.
  - Full with no pop: the word is dropped and o_ovf is set. o_ovf stays set until iClr or reset.
- FIFO is show-ahead: o_data always presents the head entry while o_vld=1. When o_vld=0, o_data is don't-care but must not be X after reset.
- Word counter, 16 bits:
  - Increments per pop.
  - When iFrameLen is non-zero and a pop takes the counter to iFrameLen: o_done pulses on the next cycle and the counter returns to 0.
- Pointer wrap-around is modulo DEPTH. Full = level==DEPTH, empty = level==0.
- iClr has priority over vld_i, pushes and pops in the same cycle. After iClr:
  - all stage valids, level, pointers, counter and o_ovf are 0;
  - o_done is 0.
- Reset mid-operation discards all in-flight and buffered words.

## Timing
- Reset values: o_data=0, o_vld=0, o_level=0, o_ovf=0, o_done=0. Internal valids, pointers and counter are also 0.
- Latency, with vld_i sampled at edge k:
  - S1 registered at k, S2 at k+1, S3 at k+2, FIFO write at k+3.
  - If the FIFO was empty, o_vld is high after edge k+3.
- Throughput is one word per cycle in and one out. A continuous stream with i_rdy=1 never fills the FIFO.
- Pop is registered at the edge where o_vld&i_rdy is sampled high. The next entry, if any, is presented immediately after that edge.
- o_done is high for exactly one cycle, following the edge of the final pop.
- iShift, iActEn and iFrameLen are sampled per stage. Changing them while words are in flight is illegal.

## Test plan
- Round-shift, iShift=4, iActEn=0, iSum0=291 -> byte0=18. Also iSum1=-1000, iShift=2 -> -250 saturates to 0x80.
- Leaky, iShift=2, iActEn=1, iSum0=-1000 -> -250>>>3=-32 (0xE0). iSum1=5000, iShift=0 -> 0x7F. iSum2=-8, iShift=0 -> -1 (0xFF).
- Latency and packing: single vld_i at edge k with sums {1,2,3,4}, iShift=0, i_rdy=1 -> o_vld after edge k+3 with o_data=0x04030201; o_vld low next cycle.
- Backpressure and overflow: i_rdy=0, DEPTH=8, 10 consecutive valids -> o_level reaches 8 and o_ovf=1. Draining gives the first 8 words in order.
- Full plus simultaneous pop: FIFO full, i_rdy=1, continuous vld_i -> o_level stays 8, no drop, o_ovf stays 0.
- Done and clear:
  - iFrameLen=5, 5 words popped -> o_done pulses once, after the 5th pop; the next 5 pops pulse again.
  - Asserting iClr mid-stream -> o_vld=0, o_level=0, o_ovf=0 on the next cycle.

Source files
------------

// File: rtl/quant_act_pack.sv
// quant_act_pack: round-shift, leaky ReLU, int8 saturate and pack of four
// adder-tree sums, buffered in a show-ahead FIFO with layer-done pulse.
module quant_act_pack #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       vld_i,
   input  logic [21:0]                iSum0,
   input  logic [21:0]                iSum1,
   input  logic [21:0]                iSum2,
   input  logic [21:0]                iSum3,
   input  logic [4:0]                 iShift,
   input  logic                       iActEn,
   input  logic [15:0]                iFrameLen,
   input  logic                       iClr,
   output logic [31:0]                o_data,
   output logic                       o_vld,
   input  logic                       i_rdy,
   output logic [$clog2(DEPTH):0]     o_level,
   output logic                       o_ovf,
   output logic                       o_done
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   function automatic logic signed [22:0] round_shift(
      input logic [21:0] s,
      input logic [4:0]  sh
   );
      logic signed [22:0] x;
      x = {s[21], s};
      if (sh != 5'd0)
         x = x + (23'sd1 <<< (sh - 5'd1));
      return x >>> sh;
   endfunction

   function automatic logic signed [22:0] leaky(
      input logic signed [22:0] v,
      input logic               en
   );
      return (en && v[22]) ? (v >>> 3) : v;
   endfunction

   function automatic logic [7:0] sat8(input logic signed [22:0] v);
      logic [7:0] r;
      if (v > 23'sd127)
         r = 8'h7F;
      else if (v < -23'sd128)
         r = 8'h80;
      else
         r = v[7:0];
      return r;
   endfunction

   logic [21:0]        sum_in [4];
   logic signed [22:0] s1_q [4];
   logic signed [22:0] s1_d [4];
   logic signed [22:0] s2_q [4];
   logic signed [22:0] s2_d [4];
   logic [31:0]        s3_q, s3_d;
   logic               s1_vld_q, s1_vld_d;
   logic               s2_vld_q, s2_vld_d;
   logic               s3_vld_q, s3_vld_d;

   logic [31:0]        mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]      level_q, level_d;
   logic               ovf_q, ovf_d;
   logic [15:0]        cnt_q, cnt_d;
   logic               done_q, done_d;

   logic               full, pop, push, drop, hit;
   logic [15:0]        cnt_nx;

   always_comb begin
      sum_in[0] = iSum0;
      sum_in[1] = iSum1;
      sum_in[2] = iSum2;
      sum_in[3] = iSum3;
   end

   // Datapath: one stage per operation, valids cleared by iClr
   always_comb begin
      s1_vld_d = vld_i & ~iClr;
      s2_vld_d = s1_vld_q & ~iClr;
      s3_vld_d = s2_vld_q & ~iClr;
      s3_d     = 32'd0;
      for (int c = 0; c < 4; c++) begin
         s1_d[c] = round_shift(sum_in[c], iShift);
         s2_d[c] = leaky(s1_q[c], iActEn);
         s3_d[c*8 +: 8] = sat8(s2_q[c]);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_vld_q <= 1'b0;
         s2_vld_q <= 1'b0;
         s3_vld_q <= 1'b0;
         s3_q     <= 32'd0;
         for (int c = 0; c < 4; c++) begin
            s1_q[c] <= 23'sd0;
            s2_q[c] <= 23'sd0;
         end
      end else begin
         s1_vld_q <= s1_vld_d;
         s2_vld_q <= s2_vld_d;
         s3_vld_q <= s3_vld_d;
         if (vld_i)
            s1_q <= s1_d;
         if (s1_vld_q)
            s2_q <= s2_d;
         if (s2_vld_q)
            s3_q <= s3_d;
      end
   end

   assign full   = (level_q == LW'(DEPTH));
   assign pop    = o_vld & i_rdy;
   // A full FIFO still accepts a word when the head leaves in the same cycle
   assign push   = s3_vld_q & (~full | pop);
   assign drop   = s3_vld_q & full & ~pop;
   assign cnt_nx = cnt_q + 16'd1;
   assign hit    = pop && (iFrameLen != 16'd0) && (cnt_nx == iFrameLen);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      if (iClr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         ovf_d    = 1'b0;
         cnt_d    = 16'd0;
      end else begin
         if (push)
            wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
         level_d = level_q + LW'(push) - LW'(pop);
         if (drop)
            ovf_d = 1'b1;
         if (pop)
            cnt_d = hit ? 16'd0 : cnt_nx;
         done_d = hit;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         cnt_q    <= 16'd0;
         done_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= 32'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         if (push && !iClr)
            mem_q[wr_ptr_q] <= s3_q;
      end
   end

   assign o_data  = mem_q[rd_ptr_q];
   assign o_vld   = (level_q != '0);
   assign o_level = level_q;
   assign o_ovf   = ovf_q;
   assign o_done  = done_q;

endmodule

// File: tb/tb_quant_act_pack.sv
// tb_quant_act_pack: directed vector table for the arithmetic plus
// hand-written sequences for latency, backpressure, overflow, done, clear.
module tb_quant_act_pack;

   logic        clk = 1'b0;
   logic        rstn;
   logic        vld_i;
   logic [21:0] iSum0, iSum1, iSum2, iSum3;
   logic [4:0]  iShift;
   logic        iActEn;
   logic [15:0] iFrameLen;
   logic        iClr;
   logic [31:0] o_data;
   logic        o_vld;
   logic        i_rdy;
   logic [3:0]  o_level;
   logic        o_ovf;
   logic        o_done;

   int n_cmp = 0;
   int n_bad = 0;

   quant_act_pack #(.DEPTH(8)) dut (
      .clk(clk), .rstn(rstn), .vld_i(vld_i),
      .iSum0(iSum0), .iSum1(iSum1), .iSum2(iSum2), .iSum3(iSum3),
      .iShift(iShift), .iActEn(iActEn), .iFrameLen(iFrameLen),
      .iClr(iClr), .o_data(o_data), .o_vld(o_vld), .i_rdy(i_rdy),
      .o_level(o_level), .o_ovf(o_ovf), .o_done(o_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [21:0] s0, s1, s2, s3;
      logic [4:0]  sh;
      logic        act;
      logic [31:0] exp;
   } vec_t;

   vec_t tv[8];

   function automatic vec_t mk(int a, int b, int c, int d,
                               int sh, bit act, logic [31:0] e);
      vec_t v;
      v.s0 = a[21:0];
      v.s1 = b[21:0];
      v.s2 = c[21:0];
      v.s3 = d[21:0];
      v.sh = sh[4:0];
      v.act = act;
      v.exp = e;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      iClr = 1'b1;
      step();
      iClr = 1'b0;
   endtask

   int lat, pops, ndone, done_at0, done_at1;
   bit pp;

   initial begin
      tv[0] = mk(291, -1000, 0, -8, 4, 0, 32'h0000C212);
      tv[1] = mk(-1000, 1000, 5, -6, 2, 0, 32'hFF017F80);
      tv[2] = mk(-1000, 100, -3, 6, 2, 1, 32'h02FF19E0);
      tv[3] = mk(5000, -8, -2048, 0, 0, 1, 32'h0080FF7F);
      tv[4] = mk(1, 2, 3, 4, 0, 0, 32'h04030201);
      tv[5] = mk(2097151, -2097152, 1048576, 1048575, 21, 0,
                 32'h0001FF01);
      tv[6] = mk(3, -3, 255, -257, 1, 0, 32'h807FFF02);
      tv[7] = mk(127, -128, 128, -129, 0, 0, 32'h807F807F);

      rstn = 1'b0; vld_i = 1'b0; iClr = 1'b0; i_rdy = 1'b0;
      iSum0 = '0; iSum1 = '0; iSum2 = '0; iSum3 = '0;
      iShift = '0; iActEn = 1'b0; iFrameLen = '0;
      #12;
      chk("rst_data", o_data, 32'd0);
      chk("rst_vld", 32'(o_vld), 32'd0);
      chk("rst_level", 32'(o_level), 32'd0);
      chk("rst_ovf", 32'(o_ovf), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      step();
      rstn = 1'b1;
      step();

      // Arithmetic table, one isolated word each, consumer always ready
      i_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         iSum0 = tv[i].s0; iSum1 = tv[i].s1;
         iSum2 = tv[i].s2; iSum3 = tv[i].s3;
         iShift = tv[i].sh; iActEn = tv[i].act;
         vld_i = 1'b1;
         step();
         vld_i = 1'b0;
         lat = 0;
         while (!o_vld && lat < 10) begin
            step();
            lat++;
         end
         chk($sformatf("lat%0d", i), 32'(lat), 32'd3);
         chk($sformatf("vec%0d", i), o_data, tv[i].exp);
         step();
         chk($sformatf("vld_low%0d", i), 32'(o_vld), 32'd0);
         chk($sformatf("nodone%0d", i), 32'(o_done), 32'd0);
      end

      // Backpressure and overflow: 10 words, only the first 8 survive
      iShift = '0; iActEn = 1'b0;
      iSum1 = '0; iSum2 = '0; iSum3 = '0;
      i_rdy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         iSum0 = 22'(i + 1);
         vld_i = 1'b1;
         step();
      end
      vld_i = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("ovf_level", 32'(o_level), 32'd8);
      chk("ovf_flag", 32'(o_ovf), 32'd1);
      i_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d", i), o_data, 32'(i + 1));
         step();
      end
      chk("drain_empty", 32'(o_vld), 32'd0);
      chk("ovf_sticky", 32'(o_ovf), 32'd1);
      clr();
      chk("ovf_clr", 32'(o_ovf), 32'd0);

      // Full with simultaneous pop: level holds at 8, nothing dropped
      i_rdy = 1'b0;
      iSum0 = 22'd1;
      vld_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step();
         iSum0 = 22'(c + 2);
         if (c >= 10) begin
            chk($sformatf("fp_level%0d", c), 32'(o_level), 32'd8);
            chk($sformatf("fp_ovf%0d", c), 32'(o_ovf), 32'd0);
            chk($sformatf("fp_head%0d", c), o_data, 32'(c - 9));
         end
         if (c == 10) i_rdy = 1'b1;
      end
      vld_i = 1'b0;
      for (int i = 0; i < 14; i++) step();
      chk("fp_drained", 32'(o_level), 32'd0);
      chk("fp_ovf_end", 32'(o_ovf), 32'd0);

      // Layer done every 5 pops
      clr();
      iFrameLen = 16'd5;
      i_rdy = 1'b1;
      pops = 0; ndone = 0; done_at0 = -1; done_at1 = -1;
      vld_i = 1'b1;
      for (int c = 0; c < 25; c++) begin
         if (c == 10) vld_i = 1'b0;
         pp = o_vld & i_rdy;
         step();
         if (pp) pops++;
         if (o_done) begin
            if (ndone == 0) done_at0 = pops;
            if (ndone == 1) done_at1 = pops;
            ndone++;
         end
      end
      chk("done_pops", 32'(pops), 32'd10);
      chk("done_cnt", 32'(ndone), 32'd2);
      chk("done_at0", 32'(done_at0), 32'd5);
      chk("done_at1", 32'(done_at1), 32'd10);
      iFrameLen = 16'd0;

      // Clear mid-stream with overflow set and words in flight
      i_rdy = 1'b0;
      vld_i = 1'b1;
      for (int i = 0; i < 12; i++) step();
      chk("pre_clr_ovf", 32'(o_ovf), 32'd1);
      iClr = 1'b1;
      step();
      iClr = 1'b0;
      vld_i = 1'b0;
      chk("clr_vld", 32'(o_vld), 32'd0);
      chk("clr_level", 32'(o_level), 32'd0);
      chk("clr_ovf", 32'(o_ovf), 32'd0);
      for (int i = 0; i < 5; i++) step();
      chk("clr_flush", 32'(o_level), 32'd0);

      // Asynchronous reset mid-operation
      vld_i = 1'b1;
      for (int i = 0; i < 3; i++) step();
      vld_i = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("pre_rst_level", 32'(o_level), 32'd3);
      rstn = 1'b0;
      #1;
      chk("arst_level", 32'(o_level), 32'd0);
      chk("arst_vld", 32'(o_vld), 32'd0);
      step();
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("arst_flush", 32'(o_level), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
